axil_seq_master: RTL

AXIL_SEQ_MASTER -- requirements
Module: axil_seq_master

---
 rtl/axil_seq_pkg.sv | 27 ++
 rtl/axil_seq_watchdog.sv | 29 ++
 rtl/axil_seq_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_seq_pkg.sv
// Shared types and constants for the AXI4-Lite write/read-back sequencer
// (axil_seq_master and its optional watchdog, enabled by AXIL_SEQ_TIMEOUT_EN).
package axil_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    FIN
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Error counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axil_seq_watchdog.sv
// Cycle watchdog for the sequencer: counts while enabled, restarts on clear,
// and flags expiry once the counter saturates at all-ones. Only instantiated
// when AXIL_SEQ_TIMEOUT_EN is defined.
module axil_seq_watchdog #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count_reg;

  assign expired = &count_reg;

  // Saturating up-counter; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/axil_seq_master.sv
// AXI4-Lite self-test master: writes SEED+i to NUM_REGS consecutive words
// starting at BASE_ADDR, reads them back and counts response/data errors.
// One transaction outstanding at a time. Define AXIL_SEQ_TIMEOUT_EN to add a
// per-state handshake watchdog that aborts the run into FIN with an error.
module axil_seq_master
  import axil_seq_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,  // only 32 is supported
  parameter int                            NUM_REGS           = 4,   // 1..16
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0]                   SEED               = 32'h0000_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t                          state_reg;
  logic [3:0]                      idx_reg;
  logic                            issued_reg;   // request phase has raised its VALIDs
  logic                            aw_done_reg;
  logic                            w_done_reg;

  logic [31:0]                     exp_data;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   reg_addr;
  logic                            aw_hs;
  logic                            w_hs;
  logic                            ar_hs;
  logic                            aw_ok;
  logic                            w_ok;
  logic                            r_bad;
  logic                            last_idx;
  logic                            timeout;

  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

  // Word address and expected data for the current index; data wraps mod 2^32.
  assign reg_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_reg, 2'b00});
  assign exp_data = SEED + 32'(idx_reg);

  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign aw_ok    = aw_done_reg || aw_hs;
  assign w_ok     = w_done_reg || w_hs;
  assign last_idx = (idx_reg == LAST_IDX);
  // A bad response and bad data on the same beat count as a single error.
  assign r_bad    = (M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RDATA != exp_data);

`ifdef AXIL_SEQ_TIMEOUT_EN
  state_t state_q_reg;
  logic   wd_expired;

  // Previous state, so the watchdog restarts on every state change.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q_reg <= IDLE;
    else        state_q_reg <= state_reg;
  end

  axil_seq_watchdog #(.WIDTH(16)) u_watchdog (
    .clk     (ACLK),
    .rst     (ARESET),
    .clear   ((state_reg != state_q_reg) || !busy),
    .enable  (busy),
    .expired (wd_expired)
  );

  assign timeout = wd_expired;
`else
  assign timeout = 1'b0;
`endif

  // Sequencer FSM; every bus and status output is a register. Request states
  // spend one cycle loading address/data before raising VALID.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      issued_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else if (timeout) begin
      // Abandon the stuck handshake and report a failed run.
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      issued_reg    <= 1'b0;
      err_cnt       <= sat_inc8(err_cnt);
      busy          <= 1'b0;
      done          <= 1'b1;
      pass          <= 1'b0;
      state_reg     <= FIN;
    end else begin
      case (state_reg)
        IDLE, FIN: begin
          if (start) begin
            err_cnt    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            idx_reg    <= '0;
            issued_reg <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!issued_reg) begin
            M_AXI_AWADDR  <= reg_addr;
            M_AXI_WDATA   <= exp_data;
            M_AXI_WSTRB   <= '1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            issued_reg    <= 1'b1;
          end else begin
            if (aw_hs) begin
              M_AXI_AWVALID <= 1'b0;
              aw_done_reg   <= 1'b1;
            end
            if (w_hs) begin
              M_AXI_WVALID <= 1'b0;
              w_done_reg   <= 1'b1;
            end
            if (aw_ok && w_ok) begin
              issued_reg   <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              state_reg    <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != AXI_RESP_OKAY) err_cnt <= sat_inc8(err_cnt);
            if (last_idx) begin
              idx_reg   <= '0;
              state_reg <= RD_REQ;
            end else begin
              idx_reg   <= idx_reg + 4'd1;
              state_reg <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!issued_reg) begin
            M_AXI_ARADDR  <= reg_addr;
            M_AXI_ARVALID <= 1'b1;
            issued_reg    <= 1'b1;
          end else if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            issued_reg    <= 1'b0;
            state_reg     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            if (r_bad) err_cnt <= sat_inc8(err_cnt);
            if (last_idx) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_cnt == 8'd0) && !r_bad;
              state_reg <= FIN;
            end else begin
              idx_reg   <= idx_reg + 4'd1;
              state_reg <= RD_REQ;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
